multicycle_add_sequencer: RTL and testbench
===========================================

MULTICYCLE_ADD_SEQUENCER -- requirements
Module: multicycle_add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter SLICE, default 8, meaning the bits per lookahead slice; it is fixed at 8.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request to begin an operation.
REQ-006 The block SHALL have port subtract, input, 1: 0 means A+B, 1 means A-B; it is sampled with start.
REQ-007 The block SHALL have port operand_a, input, WIDTH, operand A, sampled with start.
REQ-008 The block SHALL have port operand_b, input, WIDTH, operand B, sampled with start.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-011 The block SHALL have port result, output, WIDTH, the sum/difference, held until the next accepted start.
REQ-012 The block SHALL have port carry_out, output, 1, the carry out of the MSB slice (for subtract, 1 means no borrow).
REQ-013 The block SHALL have port overflow, output, 1, the two's-complement signed overflow.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted: operands and subtract are latched, the slice index is cleared to 0, the carry register is loaded with subtract, and the next state is RUN.
REQ-016 When subtract=1, the latched B SHALL be bitwise inverted (~operand_b); with carry-in 1 this forms A-B.
REQ-017 In RUN, each cycle SHALL compute one 8-bit slice k via lookahead: prop=a|b and gen=a&b per bit, with carry-in from the carry register.
REQ-018 Each RUN cycle SHALL write result[8k+7:8k], load the carry register with the slice carry-out, and increment k.
REQ-019 Slices SHALL be processed LSB first: k = 0..WIDTH/8-1.
REQ-020 When k = WIDTH/8-1, the next state SHALL be DONE.
REQ-021 Latency: for start accepted at edge E0, slice k is registered at edge E(k+1) and done=1 during the cycle after E(WIDTH/8), which is 4 RUN cycles for WIDTH=32.
REQ-022 busy SHALL be 1 exactly while the state is RUN.
REQ-023 done SHALL be 1 exactly while the state is DONE.
REQ-024 DONE without start SHALL return to IDLE after one cycle.
REQ-025 DONE with start SHALL go directly to RUN (back-to-back, no bubble).
REQ-026 start while in RUN SHALL be ignored; latched operands SHALL NOT change.
REQ-027 carry_out SHALL equal the final carry register value and be valid from DONE onward.
REQ-028 overflow SHALL be (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]), where b' is the latched, possibly inverted, B; it is valid from DONE onward.
REQ-029 result, carry_out and overflow SHALL hold their values through IDLE until the next accepted start.
REQ-030 Partial result bytes SHALL be visible during RUN but SHALL be defined valid only while done=1 and afterwards.

Reset
REQ-031 reset_n=0 SHALL immediately and asynchronously force state IDLE, k=0, carry register 0, result=0, carry_out=0, overflow=0, busy=0, done=0.
REQ-032 A reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-033 Reset deassertion SHALL be taken as synchronous to clock by the integrator; the block requires no internal synchronizer.

Structure
REQ-034 A shared package SHALL hold the FSM state type (IDLE/RUN/DONE), the SLICE_W=8 constant and the NUM_SLICES=WIDTH/SLICE_W derivation.
REQ-035 One sub-module, cla_slice8, SHALL be instantiated once; it is purely combinational, with inputs carry_in, prop[7:0], gen[7:0], a[7:0], b[7:0] and outputs sum[7:0], carry_out.
REQ-036 All sequencing, operand registers, carry register and flag logic SHALL reside in multicycle_add_sequencer.

Verification
REQ-037 The bench SHALL check: A=0xFFFFFFFF, B=0x00000001, add -> after 4 busy cycles, done pulse 1 cycle, result=0x00000000, carry_out=1, overflow=0.
REQ-038 The bench SHALL check: A=0x7FFFFFFF, B=0x00000001, add -> result=0x80000000, carry_out=0, overflow=1.
REQ-039 The bench SHALL check: A=5, B=7, subtract -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0; then A=0x80000000, B=1, subtract -> 0x7FFFFFFF, carry_out=1, overflow=1.
REQ-040 The bench SHALL check: start with A=0x12345678, B=0x11111111 add, a second start in RUN cycle 2 with other operands -> ignored, result=0x23456789, a single done pulse.
REQ-041 The bench SHALL check: start held during DONE with A=1, B=2 -> RUN entered the next cycle, second done 5 cycles after the first, result=0x00000003.
REQ-042 The bench SHALL check: reset_n pulsed low in RUN cycle 3 -> all outputs 0 immediately, no done; a new start afterwards completes correctly.

Source files
------------

// File: rtl/multicycle_add_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_add_sequencer_pkg: shared FSM state type and slice constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package multicycle_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_add_sequencer_cla_slice8.sv
// ----------------------------------------------------------------------------
// cla_slice8: combinational 8-bit carry-lookahead slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cla_slice8 (
  input  logic       carry_in,
  input  logic [7:0] prop,
  input  logic [7:0] gen,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       carry_out
);

  logic [8:0] carry;

  // Each carry is the flat OR of generate terms gated by the propagate chain above them
  always_comb begin
    logic acc;
    logic pp;
    carry    = '0;
    carry[0] = carry_in;
    for (int i = 0; i < 8; i++) begin
      acc = gen[i];
      pp  = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & gen[j]);
        pp  = pp & prop[j];
      end
      carry[i+1] = acc | (pp & carry_in);
    end
  end

  assign sum       = a ^ b ^ carry[7:0];
  assign carry_out = carry[8];

endmodule

`default_nettype wire

// File: rtl/multicycle_add_sequencer.sv
// ----------------------------------------------------------------------------
// multicycle_add_sequencer: A+B / A-B computed one 8-bit slice per clock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_add_sequencer
  import multicycle_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NUM_SLICES = num_slices(WIDTH);
  localparam int K_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_SLICES - 1);

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[int'(k_q)*SLICE +: SLICE_W];
  assign slice_b = b_q[int'(k_q)*SLICE +: SLICE_W];

  cla_slice8 u_slice (
    .carry_in  (carry_q),
    .prop      (slice_a | slice_b),
    .gen       (slice_a & slice_b),
    .a         (slice_a),
    .b         (slice_b),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      RUN: begin
        result_d[int'(k_q)*SLICE +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        k_d     = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          state_d     = DONE;
          carry_out_d = slice_cout;
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
        end
      end
      default: begin
        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          a_d     = operand_a;
          b_d     = subtract ? ~operand_b : operand_b;
          carry_d = subtract;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_multicycle_add_sequencer: scoreboard bench for the slice-serial adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_add_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        subtract = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_pulses = 0;

  multicycle_add_sequencer #(.WIDTH(32), .SLICE(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .subtract  (subtract),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic for randomised operations
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bb;
    logic [32:0] s;
    exp_t e;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    e.r = s[31:0];
    e.c = s[32];
    e.o = (a[31] == bb[31]) && (s[31] != a[31]);
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && done) begin
      exp_t e;
      done_pulses++;
      check("busy_low_in_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, e.r});
        check("carry_out", {63'd0, carry_out}, {63'd0, e.c});
        check("overflow", {63'd0, overflow}, {63'd0, e.o});
      end
    end
  end

  // Drives start for one cycle; returns on the negedge after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub, input exp_t e);
    @(negedge clock);
    sb.push_back(e);
    operand_a = a;
    operand_b = b;
    subtract  = sub;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input exp_t e);
    int bc;
    issue(a, b, sub, e);
    wait_done(tag, bc);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd4);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int   bc;
    int   gap;
    int   pulses0;
    exp_t e;

    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_flags", {62'd0, carry_out, overflow}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0});
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
    run_op("sub_borrow", 32'd5, 32'd7, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1});

    // start raised again during RUN must be ignored
    pulses0 = done_pulses;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, '{32'h2345_6789, 1'b0, 1'b0});
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h0BAD_F00D;
    subtract  = 1'b1;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    wait_done("ignore", bc);
    repeat (8) @(negedge clock);
    check("ignore_single_done", 64'(done_pulses - pulses0), 64'd1);

    // Back-to-back: start held while in DONE
    issue(32'h10, 32'h20, 1'b0, '{32'h30, 1'b0, 1'b0});
    wait_done("b2b_first", bc);
    sb.push_back('{32'h0000_0003, 1'b0, 1'b0});
    operand_a = 32'd1;
    operand_b = 32'd2;
    subtract  = 1'b0;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    check("b2b_busy_next", {63'd0, busy}, 64'd1);
    gap = 1;
    while (!done && gap < 40) begin
      @(negedge clock);
      gap++;
    end
    check("b2b_done_gap", 64'(gap), 64'd5);
    @(negedge clock);

    // Reset in RUN cycle 3 aborts the operation
    pulses0 = done_pulses;
    issue(32'hAAAA_5555, 32'h1357_9BDF, 1'b0, '{32'h0, 1'b0, 1'b0});
    repeat (2) @(negedge clock);
    check("mid_run_busy", {63'd0, busy}, 64'd1);
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_flags", {62'd0, carry_out, overflow}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("arst_no_done", 64'(done_pulses - pulses0), 64'd0);
    run_op("after_rst", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, '{32'h1010_1010, 1'b0, 1'b0});

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      e = model(a, b, s);
      run_op("rand", a, b, s, e);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
